// File: rtl/stat_dump_pkg.sv
// Shared constants, state types and helpers for the stat_dump UART frame dumper.
// STAT_DUMP_CHECKSUM_EN adds the payload XOR helper and the 22-byte frame length.
package stat_dump_pkg;

    localparam logic [7:0] HDR_BYTE        = 8'hA5;
    localparam int         NUM_WORDS       = 5;
    localparam int         PAYLOAD_BYTES   = NUM_WORDS * 4;
    localparam int         FRAME_LEN_BASE  = 21;
    localparam int         FRAME_LEN_CKSUM = 22;

    // Bit-level serializer states; DONE is the one-cycle frame-completion state.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_SEND,
        FR_DONE
    } frame_t;

`ifdef STAT_DUMP_CHECKSUM_EN
    function automatic logic [7:0] payload_xor(input logic [NUM_WORDS*32-1:0] w);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            x = x ^ w[i*8 +: 8];
        end
        return x;
    endfunction
`endif

endpackage

// File: rtl/stat_dump_if.sv
// Counter inputs, trigger levels and UART/status outputs of stat_dump.
interface stat_dump_if;
    logic        lock;
    logic        dump_req;
    logic [31:0] total;
    logic [31:0] conditional;
    logic [31:0] unconditional;
    logic [31:0] conditional_success;
    logic [31:0] lu_times;
    logic        txd;
    logic        busy;
    logic        done;

    modport master (
        output lock, dump_req, total, conditional, unconditional,
               conditional_success, lu_times,
        input  txd, busy, done
    );

    modport slave (
        input  lock, dump_req, total, conditional, unconditional,
               conditional_success, lu_times,
        output txd, busy, done
    );
endinterface

// File: rtl/stat_dump_uart_tx_byte.sv
// 8N1 byte serializer, CLK_DIV cycles per bit; txd follows the start cycle after acceptance.
// Latency: start bit on txd the cycle after start&&ready.
// Backpressure: ready only in idle or the last stop-bit cycle, which allows gapless chaining.
module uart_tx_byte
    import stat_dump_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       ready
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    state_t          state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic            bit_end;

    assign bit_end = (tmr_q == TW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_START;
            ST_START: if (bit_end) state_d = ST_DATA;
            ST_DATA:  if (bit_end && bit_q == 3'd7) state_d = ST_STOP;
            ST_STOP:  if (bit_end) state_d = start ? ST_START : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == ST_IDLE) || (state_q == ST_STOP && bit_end);
        tmr_d = (state_q == ST_IDLE || bit_end) ? '0 : tmr_q + TW'(1);
        bit_d = bit_q;
        sh_d  = sh_q;
        if (state_q != ST_DATA) begin
            bit_d = '0;
        end else if (bit_end) begin
            bit_d = bit_q + 3'd1;
        end
        if (ready && start) begin
            sh_d = data;
        end else if (state_q == ST_DATA && bit_end) begin
            sh_d = {1'b0, sh_q[7:1]};
        end
        // Decoded straight from flops so reset drives the line idle asynchronously.
        case (state_q)
            ST_START: txd = 1'b0;
            ST_DATA:  txd = sh_q[0];
            default:  txd = 1'b1;
        endcase
    end

endmodule

// File: rtl/stat_dump.sv
// Dumps five 32-bit counters as one UART frame (0xA5 + 20 payload bytes, +XOR byte with STAT_DUMP_CHECKSUM_EN).
// Latency: busy and header start bit appear the cycle after a trigger; done pulses one cycle after the last stop bit.
// Backpressure: none; triggers arriving while busy or in DONE are dropped, not queued.
module stat_dump
    import stat_dump_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic         clk,
    input  logic         rst_n,
    stat_dump_if.slave   bus
);

`ifdef STAT_DUMP_CHECKSUM_EN
    localparam int FRAME_LEN = FRAME_LEN_CKSUM;
`else
    localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif

    frame_t                  fr_q, fr_d;
    logic                    lock_q, lock_d;
    logic [4:0]              byte_idx_q, byte_idx_d;
    logic [NUM_WORDS*32-1:0] snap_q, snap_d;
    logic [NUM_WORDS*32-1:0] snap_sh;
    logic [4:0]              pidx;
    logic [7:0]              next_byte;
    logic                    trigger;
    logic                    more;
    logic                    ser_start;
    logic [7:0]              ser_data;
    logic                    ser_ready;
    logic                    ser_txd;

    uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .start (ser_start),
        .data  (ser_data),
        .txd   (ser_txd),
        .ready (ser_ready)
    );

    // lock_q resets high so a lock already asserted at reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fr_q       <= FR_IDLE;
            lock_q     <= 1'b1;
            byte_idx_q <= '0;
            snap_q     <= '0;
        end else begin
            fr_q       <= fr_d;
            lock_q     <= lock_d;
            byte_idx_q <= byte_idx_d;
            snap_q     <= snap_d;
        end
    end

    assign trigger = (fr_q == FR_IDLE) && ((bus.lock && !lock_q) || bus.dump_req);
    assign more    = (byte_idx_q < 5'(FRAME_LEN));

    always_comb begin
        fr_d = fr_q;
        case (fr_q)
            FR_IDLE: if (trigger) fr_d = FR_SEND;
            FR_SEND: if (ser_ready && !more) fr_d = FR_DONE;
            FR_DONE: fr_d = FR_IDLE;
            default: fr_d = FR_IDLE;
        endcase
    end

    always_comb begin
        pidx      = byte_idx_q - 5'd1;
        snap_sh   = snap_q >> {pidx, 3'b000};
        next_byte = snap_sh[7:0];
`ifdef STAT_DUMP_CHECKSUM_EN
        if (byte_idx_q == 5'(FRAME_LEN - 1)) begin
            next_byte = payload_xor(snap_q);
        end
`endif
        lock_d     = bus.lock;
        snap_d     = snap_q;
        byte_idx_d = byte_idx_q;
        ser_start  = 1'b0;
        ser_data   = HDR_BYTE;
        if (trigger) begin
            snap_d     = {bus.lu_times, bus.conditional_success, bus.unconditional,
                          bus.conditional, bus.total};
            ser_start  = 1'b1;
            byte_idx_d = 5'd1;
        end else if (fr_q == FR_SEND && ser_ready && more) begin
            ser_start  = 1'b1;
            ser_data   = next_byte;
            byte_idx_d = byte_idx_q + 5'd1;
        end else if (fr_q == FR_DONE) begin
            byte_idx_d = '0;
        end
    end

    always_comb begin
        bus.txd  = ser_txd;
        bus.busy = (fr_q == FR_SEND);
        bus.done = (fr_q == FR_DONE);
    end

endmodule

// File: doc/stat_dump.md
STAT_DUMP -- requirements
Module: stat_dump

Interface
REQ-001 SHALL have parameter CLK_DIV, default 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port lock  input  1  halt-lock level from the performance-counter block; a rising edge triggers a dump.
REQ-005 SHALL have port dump_req  input  1  manual dump request, already synchronized, sampled as a level.
REQ-006 SHALL have ports total, conditional, unconditional, conditional_success, lu_times  input  32 each  counter values to report.
REQ-007 SHALL have port txd  output  1  UART serial line, idle high.
REQ-008 SHALL have port busy  output  1  high while a frame is being sent.
REQ-009 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-010 SHALL treat as a trigger, while idle, either a lock rising edge (lock=1 and registered lock_q=0) or dump_req=1.
REQ-011 SHALL, on the trigger cycle, snapshot all five counters; later changes to the inputs SHALL NOT affect the frame in flight.
REQ-012 SHALL send the frame: header 0xA5, then total, conditional, unconditional, conditional_success, lu_times, each as 4 bytes LSB-first (21 bytes).
REQ-013 SHALL send each byte as 8N1: start bit 0, 8 data bits LSB-first, stop bit 1, each bit exactly CLK_DIV cycles, with no idle gap between bytes.
REQ-014 SHALL raise busy and drive the header start bit on txd starting the cycle after the trigger.
REQ-015 SHALL implement the FSM IDLE -> START -> DATA -> STOP, then START for the next byte if bytes remain, else DONE -> IDLE; DONE SHALL last one cycle, with done=1 and busy=0 during it.
REQ-016 SHALL ignore triggers while busy or in DONE; requests are not queued.
REQ-017 SHALL, when a lock rising edge and dump_req occur in the same cycle, produce exactly one frame.
REQ-018 SHALL produce exactly one frame while lock is held high; a new lock-triggered frame needs lock to fall and rise again.
REQ-019 SHALL use a bit-timer counter wide enough for CLK_DIV-1, a 3-bit bit index, and a 5-bit byte index; none SHALL wrap within a frame.

Reset
REQ-020 SHALL, while rst_n=0, force txd=1, busy=0, done=0, the FSM to IDLE, all counters to 0, snapshot registers to 0, and lock_q=1 (lock already high at reset release is not a trigger).
REQ-021 SHALL, on reset assertion mid-frame, abort the frame immediately (txd=1 asynchronously) with no done pulse.

Configuration
REQ-022 SHALL, with macro STAT_DUMP_CHECKSUM_EN defined, append byte 22: the XOR of the 20 payload bytes (header excluded). Frame length is then 22 bytes.
REQ-023 SHALL, without STAT_DUMP_CHECKSUM_EN, send exactly 21 bytes and contain no checksum logic.

Structure
REQ-024 SHALL place the following in shared package stat_dump_pkg: header constant 0xA5, NUM_WORDS=5, frame-length constants (21/22), and the FSM state typedef.
REQ-025 SHALL instantiate sub-module uart_tx_byte (byte serializer: start/data/CLK_DIV in; txd, ready out); stat_dump SHALL own triggering, snapshot, byte sequencing and checksum.

Verification (CLK_DIV=4 in simulation)
REQ-026 SHALL cover reset: hold rst_n=0 -> txd=1, busy=0, done=0; release with lock=1 -> no frame.
REQ-027 SHALL cover a basic dump: lock 0->1, total=0x12345678, others 0 -> busy high next cycle; bytes A5 78 56 34 12 then 16x 00; 21x40=840 cycles; single done pulse.
REQ-028 SHALL cover snapshot stability: change all counters to 0xFFFFFFFF mid-frame -> transmitted bytes unchanged.
REQ-029 SHALL cover ignored triggers: dump_req pulses during busy, and lock held high after the frame -> exactly one frame.
REQ-030 SHALL cover the checksum (STAT_DUMP_CHECKSUM_EN): total=0x01020304, others 0 -> byte 22 = 0x04; 22x40=880 cycles.
REQ-031 SHALL cover reset mid-frame: assert rst_n=0 during byte 5 -> txd=1 at once, busy=0, no done; a new trigger after release sends a full fresh frame.
